morph_frame_ctrl: RTL and testbench

- Frame-level sequencer/configurator for the binary 3x3 morphology engines (dilation/erosion) in the detection pipeline.
- Sits alongside the engine on the per_frame_* stream. Accepts mode configuration from the host through a valid/ready handshake and applies it only at frame boundaries.
- Gates the engine per frame, counts active pixels and lines, and flags frames whose geometry does not match IMG_HDISP x IMG_VDISP.

---
 rtl/morph_frame_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_morph_frame_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/morph_frame_ctrl.sv
// Frame-boundary sequencer and configurator for the binary 3x3 morphology engine.
// Optional watchdog on the ACTIVE state is built when MORPH_CTRL_TIMEOUT_EN is defined.
module morph_frame_ctrl #(
  parameter int IMG_HDISP   = 640,
  parameter int IMG_VDISP   = 480,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic       ctrl_start,
  input  logic       ctrl_stop,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_mode,
  input  logic       err_clr,
  output logic       morph_en,
  output logic [1:0] morph_mode,
  output logic       frame_start,
  output logic       frame_done,
  output logic       busy,
  output logic [9:0] pix_cnt,
  output logic [9:0] line_cnt,
  output logic       err_hsize,
  output logic       err_vsize,
  output logic       err_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ARMED  = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  localparam logic [9:0] H_EXP   = 10'(IMG_HDISP);
  localparam logic [9:0] V_EXP   = 10'(IMG_VDISP);
  localparam logic [9:0] CNT_MAX = 10'h3ff;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  state_e     state_q, state_d;
  logic       vsync_q, href_q;
  logic       stop_pend_q, stop_pend_d;
  logic [1:0] pend_mode_q, pend_mode_d;
  logic       cfg_ready_q, cfg_ready_d;
  logic [1:0] morph_mode_q, morph_mode_d;
  logic       morph_en_q, morph_en_d;
  logic       frame_start_q, frame_start_d;
  logic       frame_done_q, frame_done_d;
  logic       busy_q, busy_d;
  logic [9:0] pix_cnt_q, pix_cnt_d;
  logic [9:0] line_cnt_q, line_cnt_d;
  logic       err_hsize_q, err_hsize_d;
  logic       err_vsize_q, err_vsize_d;

  logic       vsync_rise, vsync_fall, href_rise, href_fall;
  logic       in_active, start_frame, end_frame, stop_now;
  logic       wd_expire, wd_abort;
  logic [9:0] pix_base, line_inc;

  assign vsync_rise  = per_frame_vsync & ~vsync_q;
  assign vsync_fall  = ~per_frame_vsync & vsync_q;
  assign href_rise   = per_frame_href & ~href_q;
  assign href_fall   = ~per_frame_href & href_q;
  assign in_active   = (state_q == ST_ACTIVE);
  assign start_frame = (state_q == ST_ARMED) & vsync_rise & ~ctrl_stop;
  assign stop_now    = stop_pend_q | ctrl_stop;
  // A normal vsync fall takes precedence over a watchdog expiry in the same cycle.
  assign wd_abort    = in_active & ~vsync_fall & wd_expire;
  assign end_frame   = (in_active & vsync_fall) | wd_abort;
  assign line_inc    = href_fall ? sat_inc(line_cnt_q) : line_cnt_q;

  // Next-state logic and pending-stop tracking.
  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      ST_IDLE: begin
        stop_pend_d = 1'b0;
        if (ctrl_start && !ctrl_stop) state_d = ST_SYNC;
        else                          state_d = ST_IDLE;
      end
      ST_SYNC: begin
        if (ctrl_stop)             state_d = ST_IDLE;
        else if (!per_frame_vsync) state_d = ST_ARMED;
        else                       state_d = ST_SYNC;
      end
      ST_ARMED: begin
        if (ctrl_stop)       state_d = ST_IDLE;
        else if (vsync_rise) state_d = ST_ACTIVE;
        else                 state_d = ST_ARMED;
      end
      ST_ACTIVE: begin
        if (in_active && vsync_fall) state_d = stop_now ? ST_IDLE : ST_ARMED;
        else if (wd_abort)           state_d = stop_now ? ST_IDLE : ST_SYNC;
        else                         state_d = ST_ACTIVE;
        stop_pend_d = end_frame ? 1'b0 : stop_now;
      end
      default: begin
        state_d     = ST_IDLE;
        stop_pend_d = 1'b0;
      end
    endcase
  end

  // Config slot and per-frame output pulses; pending mode only lands on a frame start.
  always_comb begin
    cfg_ready_d   = cfg_ready_q;
    pend_mode_d   = pend_mode_q;
    morph_mode_d  = morph_mode_q;
    if (start_frame && !cfg_ready_q) begin
      morph_mode_d = (pend_mode_q == 2'b11) ? 2'b00 : pend_mode_q;
      cfg_ready_d  = 1'b1;
    end else if (cfg_valid && cfg_ready_q) begin
      pend_mode_d = cfg_mode;
      cfg_ready_d = 1'b0;
    end else begin
      cfg_ready_d = cfg_ready_q;
    end
    morph_en_d    = (state_d == ST_ACTIVE);
    frame_start_d = start_frame;
    frame_done_d  = end_frame;
    busy_d        = (state_d != ST_IDLE);
  end

  // Pixel/line counters and sticky geometry errors; a new event beats err_clr.
  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    pix_base   = href_rise ? 10'd0 : pix_cnt_q;
    if (start_frame) begin
      line_cnt_d = 10'd0;
    end else if (in_active) begin
      line_cnt_d = line_inc;
      if (per_frame_clken && per_frame_href) pix_cnt_d = sat_inc(pix_base);
      else                                   pix_cnt_d = pix_base;
    end else begin
      line_cnt_d = line_cnt_q;
    end
    err_hsize_d = (in_active & href_fall & (pix_cnt_q != H_EXP)) | (err_hsize_q & ~err_clr);
    err_vsize_d = (in_active & vsync_fall & (line_inc != V_EXP)) | (err_vsize_q & ~err_clr);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      stop_pend_q   <= 1'b0;
      pend_mode_q   <= 2'b00;
      cfg_ready_q   <= 1'b1;
      morph_mode_q  <= 2'b00;
      morph_en_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      pix_cnt_q     <= 10'd0;
      line_cnt_q    <= 10'd0;
      err_hsize_q   <= 1'b0;
      err_vsize_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= per_frame_vsync;
      href_q        <= per_frame_href;
      stop_pend_q   <= stop_pend_d;
      pend_mode_q   <= pend_mode_d;
      cfg_ready_q   <= cfg_ready_d;
      morph_mode_q  <= morph_mode_d;
      morph_en_q    <= morph_en_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      err_hsize_q   <= err_hsize_d;
      err_vsize_q   <= err_vsize_d;
    end
  end

`ifdef MORPH_CTRL_TIMEOUT_EN
  localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYC - 1);

  logic [19:0] wd_q, wd_d;
  logic        err_timeout_q, err_timeout_d;

  // Watchdog counts cycles spent in ACTIVE, restarting on every frame entry.
  always_comb begin
    if (start_frame)    wd_d = 20'd0;
    else if (in_active) wd_d = wd_q + 20'd1;
    else                wd_d = wd_q;
    err_timeout_d = wd_abort | (err_timeout_q & ~err_clr);
  end

  assign wd_expire = in_active & (wd_q == WD_LAST);

  // Watchdog registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wd_q          <= 20'd0;
      err_timeout_q <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign wd_expire          = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  assign cfg_ready   = cfg_ready_q;
  assign morph_mode  = morph_mode_q;
  assign morph_en    = morph_en_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign pix_cnt     = pix_cnt_q;
  assign line_cnt    = line_cnt_q;
  assign err_hsize   = err_hsize_q;
  assign err_vsize   = err_vsize_q;

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// Directed self-checking bench for morph_frame_ctrl using a reduced 8x4 frame geometry.
module tb_morph_frame_ctrl;

  localparam int H = 8;
  localparam int V = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       per_frame_vsync, per_frame_href, per_frame_clken;
  logic       ctrl_start, ctrl_stop, cfg_valid, err_clr;
  logic [1:0] cfg_mode;
  logic       cfg_ready, morph_en, frame_start, frame_done, busy;
  logic [1:0] morph_mode;
  logic [9:0] pix_cnt, line_cnt;
  logic       err_hsize, err_vsize, err_timeout;

  int n_chk  = 0;
  int n_pass = 0;
  int fs_cnt = 0;
  int fd_cnt = 0;

  morph_frame_ctrl #(
    .IMG_HDISP  (H),
    .IMG_VDISP  (V),
    .TIMEOUT_CYC(1000)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .per_frame_vsync(per_frame_vsync),
    .per_frame_href (per_frame_href),
    .per_frame_clken(per_frame_clken),
    .ctrl_start     (ctrl_start),
    .ctrl_stop      (ctrl_stop),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_mode       (cfg_mode),
    .err_clr        (err_clr),
    .morph_en       (morph_en),
    .morph_mode     (morph_mode),
    .frame_start    (frame_start),
    .frame_done     (frame_done),
    .busy           (busy),
    .pix_cnt        (pix_cnt),
    .line_cnt       (line_cnt),
    .err_hsize      (err_hsize),
    .err_vsize      (err_vsize),
    .err_timeout    (err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (sys_rst_n && frame_start) fs_cnt++;
    if (sys_rst_n && frame_done)  fd_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic frame_open;
    per_frame_vsync = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    check_eq("frame_start_after_rise", 32'(frame_start), 32'd1);
    check_eq("morph_en_at_start", 32'(morph_en), 32'd1);
    step(1);
    check_eq("frame_start_one_cycle", 32'(frame_start), 32'd0);
  endtask

  task automatic frame_lines(input int lines, input int bad_line, input int bad_len, input bit clr_on_bad);
    for (int l = 0; l < lines; l++) begin
      per_frame_href  = 1'b1;
      per_frame_clken = 1'b1;
      step((l == bad_line) ? bad_len : H);
      per_frame_href  = 1'b0;
      per_frame_clken = 1'b0;
      if (l == bad_line && clr_on_bad) err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      if (l == bad_line) begin
        check_eq("hsize_set_on_short_line", 32'(err_hsize), 32'd1);
        if (clr_on_bad) check_eq("vsize_cleared_by_clr", 32'(err_vsize), 32'd0);
      end
      step(1);
    end
  endtask

  task automatic frame_close;
    per_frame_vsync = 1'b0;
    step(1);
    check_eq("frame_done_after_fall", 32'(frame_done), 32'd1);
    check_eq("morph_en_off_after_fall", 32'(morph_en), 32'd0);
    step(1);
    check_eq("frame_done_one_cycle", 32'(frame_done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fs0, fd0, n_wd;
    bit seen;
    sys_rst_n = 1'b0;
    per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0;
    ctrl_start = 1'b0; ctrl_stop = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'b00; err_clr = 1'b0;
    step(2);
    check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_morph_mode", 32'(morph_mode), 32'd0);
    check_eq("rst_morph_en", 32'(morph_en), 32'd0);
    check_eq("rst_err_any", 32'({err_hsize, err_vsize, err_timeout}), 32'd0);
    sys_rst_n = 1'b1;
    step(1);

    // Nominal frame with dilate config.
    cfg_valid = 1'b1; cfg_mode = 2'b10;
    step(1);
    cfg_valid = 1'b0;
    check_eq("cfg_accepted_ready_low", 32'(cfg_ready), 32'd0);
    ctrl_start = 1'b1;
    step(1);
    ctrl_start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    step(1);
    frame_open();
    check_eq("nominal_mode_dilate", 32'(morph_mode), 32'd2);
    check_eq("nominal_cfg_ready_back", 32'(cfg_ready), 32'd1);
    check_eq("nominal_line_cnt_cleared", 32'(line_cnt), 32'd0);
    frame_lines(V, -1, 0, 1'b0);
    check_eq("nominal_pix_cnt", 32'(pix_cnt), 32'(H));
    check_eq("nominal_line_cnt", 32'(line_cnt), 32'(V));
    check_eq("nominal_morph_en_mid", 32'(morph_en), 32'd1);
    frame_close();
    check_eq("nominal_no_errors", 32'({err_hsize, err_vsize, err_timeout}), 32'd0);

    // Short line and short frame, then err_clr colliding with a new hsize event.
    frame_open();
    frame_lines(V - 1, 1, H - 1, 1'b0);
    frame_close();
    check_eq("vsize_set_short_frame", 32'(err_vsize), 32'd1);
    frame_open();
    frame_lines(V, 0, H - 1, 1'b1);
    frame_close();
    check_eq("vsize_clear_full_frame", 32'(err_vsize), 32'd0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check_eq("hsize_cleared", 32'(err_hsize), 32'd0);

    // Handshake on the vsync-rise cycle applies to the following frame.
    cfg_valid = 1'b1; cfg_mode = 2'b01;
    frame_open();
    check_eq("cfg_on_rise_keeps_old_mode", 32'(morph_mode), 32'd2);
    check_eq("cfg_on_rise_captured", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b1; cfg_mode = 2'b00;
    step(2);
    cfg_valid = 1'b0;
    check_eq("second_cfg_blocked", 32'(cfg_ready), 32'd0);
    frame_lines(V, -1, 0, 1'b0);
    frame_close();
    frame_open();
    check_eq("next_frame_new_mode", 32'(morph_mode), 32'd1);
    check_eq("next_frame_cfg_ready", 32'(cfg_ready), 32'd1);

    // Stop mid-frame finishes the frame, then idles.
    frame_lines(2, -1, 0, 1'b0);
    ctrl_stop = 1'b1;
    step(1);
    ctrl_stop = 1'b0;
    check_eq("stop_pending_busy", 32'(busy), 32'd1);
    check_eq("stop_pending_morph_en", 32'(morph_en), 32'd1);
    frame_lines(2, -1, 0, 1'b0);
    frame_close();
    check_eq("stop_idle_busy", 32'(busy), 32'd0);
    ctrl_start = 1'b1; ctrl_stop = 1'b1;
    step(1);
    ctrl_start = 1'b0; ctrl_stop = 1'b0;
    check_eq("start_stop_together_idle", 32'(busy), 32'd0);

    // Start while a frame is already running: join only the next full frame.
    per_frame_vsync = 1'b1;
    step(3);
    ctrl_start = 1'b1;
    step(1);
    ctrl_start = 1'b0;
    check_eq("midframe_start_busy", 32'(busy), 32'd1);
    fs0 = fs_cnt;
    fd0 = fd_cnt;
    frame_lines(2, -1, 0, 1'b0);
    check_eq("midframe_no_morph_en", 32'(morph_en), 32'd0);
    per_frame_vsync = 1'b0;
    step(2);
    check_eq("midframe_no_frame_start", 32'(fs_cnt), 32'(fs0));
    check_eq("midframe_no_frame_done", 32'(fd_cnt), 32'(fd0));
    frame_open();
    frame_lines(V, -1, 0, 1'b0);
    frame_close();
    check_eq("midframe_next_frame_started", 32'(fs_cnt), 32'(fs0 + 1));

    // Reset in the middle of a frame.
    frame_open();
    frame_lines(2, -1, 0, 1'b0);
    fd0 = fd_cnt;
    sys_rst_n = 1'b0;
    step(1);
    check_eq("rst_mid_morph_en", 32'(morph_en), 32'd0);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_line_cnt", 32'(line_cnt), 32'd0);
    check_eq("rst_mid_cfg_ready", 32'(cfg_ready), 32'd1);
    check_eq("rst_mid_morph_mode", 32'(morph_mode), 32'd0);
    per_frame_vsync = 1'b0;
    step(2);
    sys_rst_n = 1'b1;
    step(2);
    check_eq("rst_mid_no_frame_done", 32'(fd_cnt), 32'(fd0));

    // vsync held high far beyond the watchdog limit.
    ctrl_start = 1'b1;
    step(1);
    ctrl_start = 1'b0;
    step(1);
    per_frame_vsync = 1'b1;
    step(1);
    check_eq("wd_frame_start", 32'(frame_start), 32'd1);
    fd0 = fd_cnt;
    n_wd = 0;
    seen = 1'b0;
    for (int i = 0; i < 1500 && !seen; i++) begin
      step(1);
      n_wd++;
      if (frame_done) seen = 1'b1;
    end
`ifdef MORPH_CTRL_TIMEOUT_EN
    check_eq("wd_abort_cycle", 32'(n_wd), 32'd1000);
    check_eq("wd_err_timeout", 32'(err_timeout), 32'd1);
    check_eq("wd_morph_en_dropped", 32'(morph_en), 32'd0);
    check_eq("wd_busy_resync", 32'(busy), 32'd1);
    step(2000 - n_wd);
    per_frame_vsync = 1'b0;
    step(3);
    check_eq("wd_single_frame_done", 32'(fd_cnt), 32'(fd0 + 1));
`else
    check_eq("no_wd_abort", 32'(seen), 32'd0);
    check_eq("no_wd_err_timeout", 32'(err_timeout), 32'd0);
    check_eq("no_wd_morph_en_held", 32'(morph_en), 32'd1);
    step(500);
    per_frame_vsync = 1'b0;
    step(1);
    check_eq("no_wd_frame_done_on_fall", 32'(frame_done), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
